// File: rtl/mul_div_sequencer.sv
// Control sequencer for the iterative M-extension multiply/divide unit in Execute.
// It starts and steps the unit, and it freezes F/D/E until the result is final.
module mul_div_sequencer #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_MulDivE,
    input  logic [2:0] i_Funct3E,
    input  logic       i_SrcBZeroE,
    input  logic       i_KillE,
    output logic       o_StallF,
    output logic       o_StallD,
    output logic       o_StallE,
    output logic       o_FlushM,
    output logic       o_UnitStart,
    output logic       o_UnitStep,
    output logic [2:0] o_UnitOp,
    output logic       o_ResultValid,
    output logic       o_Busy
);

    if (XLEN == 0 || MUL_CYCLES < 1 || MUL_CYCLES > 63 ||
        DIV_CYCLES < 1 || DIV_CYCLES > 63) begin : gBadParams
        $error("mul_div_sequencer: XLEN/MUL_CYCLES/DIV_CYCLES out of range");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

    localparam logic [5:0] MulLoad = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DivLoad = 6'(DIV_CYCLES - 1);

    stateT      stateQ, stateD;
    logic [5:0] cntQ, cntD;
    logic [2:0] opQ, opD;
    logic       startReq;
    logic       frontStall;

    assign startReq = i_MulDivE && !i_KillE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stateQ <= StIdle;
            cntQ   <= 6'd0;
            opQ    <= 3'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            opQ    <= opD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        opD    = opQ;
        if (i_KillE) begin
            stateD = StIdle;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (startReq) begin
                        opD = i_Funct3E;
                        // Divide by zero: the unit's start load already yields the defined result.
                        if (i_Funct3E[2] && i_SrcBZeroE) begin
                            stateD = StDone;
                        end else begin
                            cntD   = i_Funct3E[2] ? DivLoad : MulLoad;
                            stateD = StRun;
                        end
                    end
                end
                StRun: begin
                    if (cntQ == 6'd0) begin
                        stateD = StDone;
                    end else begin
                        cntD = cntQ - 6'd1;
                    end
                end
                StDone: stateD = StIdle;
                default: stateD = StIdle;
            endcase
        end
    end

    always_comb begin
        o_UnitStart   = 1'b0;
        o_UnitStep    = 1'b0;
        o_ResultValid = 1'b0;
        frontStall    = 1'b0;
        if (!i_KillE) begin
            unique case (stateQ)
                StIdle: begin
                    o_UnitStart = i_MulDivE;
                    frontStall  = i_MulDivE;
                end
                StRun: begin
                    o_UnitStep = 1'b1;
                    frontStall = 1'b1;
                end
                StDone: o_ResultValid = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_StallF = frontStall;
    assign o_StallD = frontStall;
    assign o_StallE = frontStall;
    assign o_FlushM = frontStall;
    assign o_UnitOp = opQ;
    assign o_Busy   = (stateQ != StIdle);

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: a cycle model built on "steps still owed" checks every
// output at each falling edge; directed ops pin latencies, step counts and kill/reset.
module tb_mul_div_sequencer;

    localparam int unsigned MulN = 4;
    localparam int unsigned DivN = 32;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_MulDivE;
    logic [2:0] i_Funct3E;
    logic       i_SrcBZeroE;
    logic       i_KillE;
    logic       o_StallF, o_StallD, o_StallE, o_FlushM;
    logic       o_UnitStart, o_UnitStep, o_ResultValid, o_Busy;
    logic [2:0] o_UnitOp;

    mul_div_sequencer #(
        .XLEN      (32),
        .MUL_CYCLES(MulN),
        .DIV_CYCLES(DivN)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_MulDivE    (i_MulDivE),
        .i_Funct3E    (i_Funct3E),
        .i_SrcBZeroE  (i_SrcBZeroE),
        .i_KillE      (i_KillE),
        .o_StallF     (o_StallF),
        .o_StallD     (o_StallD),
        .o_StallE     (o_StallE),
        .o_FlushM     (o_FlushM),
        .o_UnitStart  (o_UnitStart),
        .o_UnitStep   (o_UnitStep),
        .o_UnitOp     (o_UnitOp),
        .o_ResultValid(o_ResultValid),
        .o_Busy       (o_Busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: an op in flight owes mSteps more step cycles, then one result cycle.
    bit         mBusy;
    int         mSteps;
    logic [2:0] mOp;
    logic       eStart, eStep, eValid, eStall;
    logic [10:0] expVec, actVec;

    // Observed-timing monitor used by the directed literal checks.
    int cyc = 0;
    int startCyc = 0;
    int stepCnt = 0;
    int lastOcc = -1;
    int lastSteps = -1;
    int lastValidCyc = -100;
    int lastGap = -1;
    int validCnt = 0;

    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst_n) begin
            mBusy  = 1'b0;
            mSteps = 0;
            mOp    = 3'd0;
        end
        eStart = 1'b0; eStep = 1'b0; eValid = 1'b0; eStall = 1'b0;
        if (!mBusy) begin
            if (i_MulDivE && !i_KillE) begin
                eStart = 1'b1;
                eStall = 1'b1;
            end
        end else if (!i_KillE) begin
            if (mSteps > 0) begin
                eStep  = 1'b1;
                eStall = 1'b1;
            end else begin
                eValid = 1'b1;
            end
        end
        expVec = {eStart, eStep, eValid, eStall, eStall, eStall, eStall, mBusy, mOp};
        actVec = {o_UnitStart, o_UnitStep, o_ResultValid, o_StallF, o_StallD, o_StallE,
                  o_FlushM, o_Busy, o_UnitOp};
        chk("cycle", 32'(actVec), 32'(expVec));

        if (i_rst_n) begin
            if (!mBusy) begin
                if (i_MulDivE && !i_KillE) begin
                    mBusy  = 1'b1;
                    mOp    = i_Funct3E;
                    mSteps = (i_Funct3E[2] && i_SrcBZeroE) ? 0
                           : (i_Funct3E[2] ? int'(DivN) : int'(MulN));
                end
            end else if (i_KillE) begin
                mBusy = 1'b0;
            end else if (mSteps > 0) begin
                mSteps--;
            end else begin
                mBusy = 1'b0;
            end
        end

        if (o_UnitStart) begin
            startCyc = cyc;
            stepCnt  = 0;
            lastGap  = cyc - lastValidCyc;
        end
        if (o_UnitStep) stepCnt++;
        if (o_ResultValid) begin
            lastOcc      = cyc - startCyc + 1;
            lastSteps    = stepCnt;
            lastValidCyc = cyc;
            validCnt++;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic runOp(input logic [2:0] f3, input logic bz, input int hold);
        i_MulDivE   = 1'b1;
        i_Funct3E   = f3;
        i_SrcBZeroE = bz;
        repeat (hold) tick();
        i_MulDivE   = 1'b0;
        i_SrcBZeroE = 1'b0;
    endtask

    int vBefore;

    initial begin
        i_rst_n = 1'b0; i_MulDivE = 1'b0; i_Funct3E = 3'd0; i_SrcBZeroE = 1'b0; i_KillE = 1'b0;
        #1;
        chk("reset_busy", 32'(o_Busy), 32'd0);
        chk("reset_stall", 32'({o_StallF, o_StallD, o_StallE, o_FlushM}), 32'd0);
        chk("reset_op", 32'(o_UnitOp), 32'd0);
        repeat (3) tick();
        i_rst_n = 1'b1;
        repeat (2) tick();

        // MUL: 4 steps, valid at cycle 5, occupies E for 6 cycles.
        runOp(3'b000, 1'b0, 6);
        tick();
        chk("mul_occ", 32'(lastOcc), 32'd6);
        chk("mul_steps", 32'(lastSteps), 32'd4);

        // DIVU: 32 steps, valid at cycle 33.
        runOp(3'b101, 1'b0, 34);
        tick();
        chk("divu_occ", 32'(lastOcc), 32'd34);
        chk("divu_steps", 32'(lastSteps), 32'd32);
        chk("divu_op", 32'(o_UnitOp), 32'd5);

        // DIV by zero: no steps, valid at cycle 1.
        runOp(3'b100, 1'b1, 2);
        tick();
        chk("dz_occ", 32'(lastOcc), 32'd2);
        chk("dz_steps", 32'(lastSteps), 32'd0);

        // Back-to-back MUL then DIVU with no dead cycle.
        i_MulDivE = 1'b1; i_Funct3E = 3'b000;
        repeat (6) tick();
        chk("b2b_mul_occ", 32'(lastOcc), 32'd6);
        i_Funct3E = 3'b101;
        repeat (34) tick();
        i_MulDivE = 1'b0;
        tick();
        chk("b2b_gap", 32'(lastGap), 32'd1);
        chk("b2b_divu_occ", 32'(lastOcc), 32'd34);

        // REM killed in its 10th RUN cycle: no result.
        vBefore = validCnt;
        i_MulDivE = 1'b1; i_Funct3E = 3'b110;
        repeat (10) tick();
        i_KillE = 1'b1;
        #1;
        chk("kill_step", 32'({o_UnitStep, o_StallF, o_FlushM, o_ResultValid}), 32'd0);
        tick();
        i_KillE = 1'b0; i_MulDivE = 1'b0;
        chk("kill_idle", 32'(o_Busy), 32'd0);
        repeat (4) tick();
        chk("kill_novalid", 32'(validCnt), 32'(vBefore));

        // Asynchronous reset in the middle of a DIVU.
        vBefore = validCnt;
        runOp(3'b101, 1'b0, 5);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(o_Busy), 32'd0);
        chk("rst_outs", 32'({o_UnitStep, o_StallF, o_StallE, o_FlushM, o_ResultValid}), 32'd0);
        chk("rst_op", 32'(o_UnitOp), 32'd0);
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
        runOp(3'b011, 1'b0, 6);
        tick();
        chk("rst_novalid", 32'(validCnt), 32'(vBefore + 1));
        chk("post_rst_occ", 32'(lastOcc), 32'd6);
        chk("post_rst_steps", 32'(lastSteps), 32'd4);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            i_MulDivE   = ($urandom_range(0, 2) != 0);
            i_Funct3E   = 3'($urandom);
            i_SrcBZeroE = ($urandom_range(0, 3) == 0);
            i_KillE     = ($urandom_range(0, 31) == 0);
            tick();
        end
        i_MulDivE = 1'b0; i_KillE = 1'b0;
        repeat (70) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
